// File: rtl/req_router.sv
// rtl/req_router.sv - Routes nodeset requests by tag to per-destination registered slots with round-robin arbitration.
module req_router #(
    parameter int NUM_NODESETS = 8,
    parameter int NUM_PATHS_DW = 16
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic [NUM_NODESETS-1:0]                  i_src_vld,
    input  logic [NUM_NODESETS*(NUM_PATHS_DW+2)-1:0] i_src_payload,
    input  logic [NUM_NODESETS*12-1:0]               i_src_nodenum,
    output logic [NUM_NODESETS-1:0]                  o_src_ack,
    output logic [NUM_NODESETS-1:0]                  o_dst_vld,
    output logic [NUM_NODESETS*(NUM_PATHS_DW+2)-1:0] o_dst_payload,
    output logic [NUM_NODESETS*6-1:0]                o_dst_nodenum,
    input  logic [NUM_NODESETS-1:0]                  i_dst_ack,
    output logic                                     o_idle,
    output logic                                     o_err,
    output logic [31:0]                              o_num_routed
);

    localparam int PW    = NUM_PATHS_DW + 2;
    localparam int PTR_W = (NUM_NODESETS > 1) ? $clog2(NUM_NODESETS) : 1;

    logic [NUM_NODESETS-1:0] dst_vld_q, dst_vld_d;
    logic [PW-1:0]           dst_payload_q [NUM_NODESETS];
    logic [PW-1:0]           dst_payload_d [NUM_NODESETS];
    logic [5:0]              dst_nodenum_q [NUM_NODESETS];
    logic [5:0]              dst_nodenum_d [NUM_NODESETS];
    logic [PTR_W-1:0]        rr_ptr_q [NUM_NODESETS];
    logic [PTR_W-1:0]        rr_ptr_d [NUM_NODESETS];
    logic                    err_q, err_d;
    logic [31:0]             num_routed_q, num_routed_d;
    logic [NUM_NODESETS-1:0] src_ack;

    always_comb begin
        int       idx;
        int       grant;
        logic     found;
        logic [31:0] routed;
        dst_vld_d     = dst_vld_q;
        dst_payload_d = dst_payload_q;
        dst_nodenum_d = dst_nodenum_q;
        rr_ptr_d      = rr_ptr_q;
        err_d         = err_q;
        src_ack       = '0;
        routed        = '0;
        idx           = 0;
        grant         = 0;
        found         = 1'b0;
        for (int d = 0; d < NUM_NODESETS; d++) begin
            if (!dst_vld_q[d] || i_dst_ack[d]) begin
                found = 1'b0;
                grant = 0;
                // Scan from the pointer with wrap; first hit wins.
                for (int k = 0; k < NUM_NODESETS; k++) begin
                    idx = int'(rr_ptr_q[d]) + k;
                    if (idx >= NUM_NODESETS) idx = idx - NUM_NODESETS;
                    if (!found && i_src_vld[idx] &&
                        int'(i_src_nodenum[idx*12+6 +: 6]) == d) begin
                        found = 1'b1;
                        grant = idx;
                    end
                end
                if (found) begin
                    src_ack[grant]   = 1'b1;
                    dst_vld_d[d]     = 1'b1;
                    dst_payload_d[d] = i_src_payload[grant*PW +: PW];
                    dst_nodenum_d[d] = i_src_nodenum[grant*12 +: 6];
                    rr_ptr_d[d]      = (grant + 1 == NUM_NODESETS) ? '0 : PTR_W'(grant + 1);
                    routed           = routed + 32'd1;
                end else begin
                    dst_vld_d[d] = 1'b0;
                end
            end
        end
        // Requests to a nonexistent nodeset are swallowed and flagged.
        for (int s = 0; s < NUM_NODESETS; s++) begin
            if (i_src_vld[s] && int'(i_src_nodenum[s*12+6 +: 6]) >= NUM_NODESETS) begin
                src_ack[s] = 1'b1;
                err_d      = 1'b1;
            end
        end
        num_routed_d = num_routed_q + routed;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_vld_q    <= '0;
            err_q        <= 1'b0;
            num_routed_q <= '0;
            for (int d = 0; d < NUM_NODESETS; d++) begin
                dst_payload_q[d] <= '0;
                dst_nodenum_q[d] <= '0;
                rr_ptr_q[d]      <= '0;
            end
        end else begin
            dst_vld_q     <= dst_vld_d;
            dst_payload_q <= dst_payload_d;
            dst_nodenum_q <= dst_nodenum_d;
            rr_ptr_q      <= rr_ptr_d;
            err_q         <= err_d;
            num_routed_q  <= num_routed_d;
        end
    end

    for (genvar g = 0; g < NUM_NODESETS; g++) begin : g_pack
        assign o_dst_payload[g*PW +: PW] = dst_payload_q[g];
        assign o_dst_nodenum[g*6 +: 6]   = dst_nodenum_q[g];
    end

    assign o_src_ack    = src_ack;
    assign o_dst_vld    = dst_vld_q;
    assign o_err        = err_q;
    assign o_num_routed = num_routed_q;
    assign o_idle       = ~|i_src_vld & ~|dst_vld_q;

endmodule

// File: tb/tb_req_router.sv
// tb/tb_req_router.sv - Scoreboard bench for req_router.
module tb_req_router;

    localparam int N  = 8;
    localparam int PW = 18;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N-1:0]    src_vld;
    logic [N*PW-1:0] src_payload;
    logic [N*12-1:0] src_nodenum;
    logic [N-1:0]    src_ack;
    logic [N-1:0]    dst_vld;
    logic [N*PW-1:0] dst_payload;
    logic [N*6-1:0]  dst_nodenum;
    logic [N-1:0]    dst_ack;
    logic            idle;
    logic            err;
    logic [31:0]     num_routed;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          exp_routed = 0;
    logic [23:0] exp_q [N][$];
    logic [23:0] exp_e;

    req_router #(.NUM_NODESETS(N), .NUM_PATHS_DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_src_vld(src_vld), .i_src_payload(src_payload), .i_src_nodenum(src_nodenum),
        .o_src_ack(src_ack),
        .o_dst_vld(dst_vld), .o_dst_payload(dst_payload), .o_dst_nodenum(dst_nodenum),
        .i_dst_ack(dst_ack),
        .o_idle(idle), .o_err(err), .o_num_routed(num_routed)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int s, input logic [11:0] tag, input logic [17:0] pl);
        src_vld[s]              = 1'b1;
        src_nodenum[s*12 +: 12] = tag;
        src_payload[s*PW +: PW] = pl;
    endtask

    task automatic push(input int d, input logic [17:0] pl, input logic [5:0] loc);
        exp_q[d].push_back({pl, loc});
    endtask

    // Every handshaked slot must match the oldest expectation for that destination.
    always @(negedge clk) begin
        if (rst_n) begin
            for (int d = 0; d < N; d++) begin
                if (dst_vld[d] && dst_ack[d]) begin
                    if (exp_q[d].size() == 0) begin
                        check($sformatf("unexpected_d%0d", d), 32'd1, 32'd0);
                    end else begin
                        exp_e = exp_q[d].pop_front();
                        check($sformatf("deliver_d%0d", d),
                              32'({dst_payload[d*PW +: PW], dst_nodenum[d*6 +: 6]}), 32'(exp_e));
                    end
                end
            end
        end
    end

    initial begin
        int order [6] = '{0, 1, 4, 0, 1, 4};
        rst_n       = 1'b0;
        src_vld     = '0;
        src_payload = '0;
        src_nodenum = '0;
        dst_ack     = '1;
        repeat (3) tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_dst_vld", 32'(dst_vld), 32'd0);
        check("rst_src_ack", 32'(src_ack), 32'd0);
        check("rst_idle", 32'(idle), 32'd1);
        check("rst_err", 32'(err), 32'd0);
        check("rst_routed", num_routed, 32'd0);

        // Single request
        tick();
        set_src(2, 12'h0C5, 18'h00014);
        push(3, 18'h00014, 6'd5);
        @(negedge clk);
        check("single_ack", 32'(src_ack), 32'h04);
        tick();
        src_vld = '0;
        @(negedge clk);
        exp_routed = 1;
        check("single_vld", 32'(dst_vld), 32'h08);
        check("single_routed", num_routed, 32'(exp_routed));
        check("single_idle_busy", 32'(idle), 32'd0);
        tick();
        @(negedge clk);
        check("single_drained", 32'(dst_vld), 32'd0);
        check("single_idle", 32'(idle), 32'd1);

        // Contention on dest 6 with wrap of the round-robin pointer
        tick();
        set_src(0, 12'h180, 18'h00100);
        set_src(1, 12'h181, 18'h00101);
        set_src(4, 12'h184, 18'h00104);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) tick();
            push(6, 18'h00100 + 18'(order[i]), 6'(order[i]));
            @(negedge clk);
            check($sformatf("rr_ack_%0d", i), 32'(src_ack), 32'd1 << order[i]);
            if (i > 0) check($sformatf("rr_vld_%0d", i), 32'(dst_vld[6]), 32'd1);
        end
        tick();
        src_vld = '0;
        @(negedge clk);
        exp_routed += 6;
        check("rr_vld_last", 32'(dst_vld[6]), 32'd1);
        check("rr_routed", num_routed, 32'(exp_routed));
        tick();
        @(negedge clk);
        check("rr_drained", 32'(dst_vld), 32'd0);

        // Backpressure on dest 1
        tick();
        dst_ack[1] = 1'b0;
        set_src(3, 12'h047, 18'h00033);
        push(1, 18'h00033, 6'd7);
        @(negedge clk);
        check("bp_first_ack", 32'(src_ack), 32'h08);
        for (int i = 0; i < 5; i++) begin
            tick();
            set_src(3, 12'h048, 18'h00034);
            @(negedge clk);
            check($sformatf("bp_hold_ack_%0d", i), 32'(src_ack), 32'd0);
            check($sformatf("bp_hold_vld_%0d", i), 32'(dst_vld[1]), 32'd1);
            check($sformatf("bp_hold_pl_%0d", i), 32'(dst_payload[1*PW +: PW]), 32'h33);
        end
        tick();
        dst_ack[1] = 1'b1;
        push(1, 18'h00034, 6'd8);
        @(negedge clk);
        check("bp_release_ack", 32'(src_ack), 32'h08);
        tick();
        src_vld = '0;
        @(negedge clk);
        exp_routed += 2;
        check("bp_routed", num_routed, 32'(exp_routed));

        // Parallel routes, every source to a distinct destination
        tick();
        for (int s = 0; s < N; s++) begin
            set_src(s, {6'((s + 1) % N), 6'(s)}, 18'h00200 + 18'(s));
            push((s + 1) % N, 18'h00200 + 18'(s), 6'(s));
        end
        @(negedge clk);
        check("par_ack", 32'(src_ack), 32'hFF);
        tick();
        src_vld = '0;
        @(negedge clk);
        exp_routed += 8;
        check("par_vld", 32'(dst_vld), 32'hFF);
        check("par_routed", num_routed, 32'(exp_routed));
        tick();

        // Out-of-range destination tag
        tick();
        set_src(5, 12'hA00, 18'h00055);
        @(negedge clk);
        check("bad_ack", 32'(src_ack), 32'h20);
        tick();
        src_vld = '0;
        @(negedge clk);
        check("bad_no_vld", 32'(dst_vld), 32'd0);
        check("bad_err", 32'(err), 32'd1);
        check("bad_routed", num_routed, 32'(exp_routed));
        tick();
        @(negedge clk);
        check("bad_err_sticky", 32'(err), 32'd1);

        // Reset with held slots
        tick();
        dst_ack = '0;
        set_src(0, 12'h001, 18'h00010);
        set_src(1, 12'h041, 18'h00011);
        set_src(2, 12'h081, 18'h00012);
        @(negedge clk);
        check("rst_fill_ack", 32'(src_ack), 32'h07);
        tick();
        src_vld = '0;
        @(negedge clk);
        check("rst_fill_vld", 32'(dst_vld), 32'h07);
        tick();
        rst_n = 1'b0;
        #1;
        check("rst_async_vld", 32'(dst_vld), 32'd0);
        repeat (2) tick();
        rst_n   = 1'b1;
        dst_ack = '1;
        @(negedge clk);
        check("post_rst_idle", 32'(idle), 32'd1);
        check("post_rst_routed", num_routed, 32'd0);
        check("post_rst_err", 32'(err), 32'd0);
        tick();
        @(negedge clk);
        check("post_rst_vld", 32'(dst_vld), 32'd0);

        for (int d = 0; d < N; d++)
            check($sformatf("leftover_d%0d", d), 32'(exp_q[d].size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
